// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Single outstanding transaction with a bounded wait for m_ack.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata,
  output logic            bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]      state;
  logic            gnt_d;
  logic            last_d;
  logic            err;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] ird_q;
  logic [XLEN-1:0] drd_q;
  logic            pick_d;
  logic            expire;
  logic [XLEN-1:0] rd;

  // On a tie, data wins only if fetch was granted last
  assign pick_d = d_req & (~i_req | ~last_d);
  assign expire = (cnt == CW'(TIMEOUT - 1));
  assign rd     = we_q ? '0 : m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_d   <= 1'b0;
      last_d  <= 1'b1;
      err     <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req | d_req) begin
            gnt_d   <= pick_d;
            last_d  <= pick_d;
            we_q    <= pick_d & d_we;
            addr_q  <= pick_d ? d_addr : i_addr;
            wdata_q <= (pick_d & d_we) ? d_wdata : '0;
            cnt     <= '0;
            err     <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack) begin
            if (gnt_d) drd_q <= rd;
            else       ird_q <= rd;
            state <= RESP;
          end else if (expire) begin
            if (gnt_d) drd_q <= '0;
            else       ird_q <= '0;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs forced low combinationally while reset is held
  assign m_req   = ~rst & (state == BUSY);
  assign m_we    = ~rst & (state == BUSY) & we_q;
  assign m_addr  = rst ? '0 : addr_q;
  assign m_wdata = rst ? '0 : wdata_q;
  assign i_ack   = ~rst & (state == RESP) & ~gnt_d;
  assign d_ack   = ~rst & (state == RESP) & gnt_d;
  assign bus_err = ~rst & (state == RESP) & err;
  assign i_rdata = rst ? '0 : ird_q;
  assign d_rdata = rst ? '0 : drd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// hand-written reset, tie and idle-ack sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_ack, d_ack, m_req, m_we, bus_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          delay;
    logic [31:0] mrd;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int busy;
    int bad;
    @(negedge clk);
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we;
    d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'hFFFF_FFFF; d_addr = 32'hFFFF_FFFF;
    d_wdata = 32'h5555_5555; d_we = ~d_we;
    busy = 0; bad = 0;
    while (m_req && busy < 40) begin
      busy++;
      if (m_addr !== v.exp_addr || m_we !== v.exp_we ||
          m_wdata !== v.exp_wdata || i_ack || d_ack)
        bad++;
      m_ack = (busy == v.delay);
      m_rdata = v.mrd;
      @(negedge clk);
    end
    m_ack = 1'b0;
    m_rdata = 32'h0BAD_0BAD;
    chk("busy_bus", bad, 0);
    chk("busy_len", busy, v.exp_busy);
    chk("ack_i", i_ack, !v.exp_d);
    chk("ack_d", d_ack, v.exp_d);
    chk("bus_err", bus_err, v.exp_err);
    chk("rdata", v.exp_d ? d_rdata : i_rdata, v.exp_rdata);
    @(negedge clk);
    chk("ack_drop", {i_ack, d_ack, bus_err}, 3'b000);
    chk("rdata_hold", v.exp_d ? d_rdata : i_rdata, v.exp_rdata);
  endtask

  initial begin
    int got[4];
    int n;
    vec_t f;
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0,
                1, 32'h0050_0093, 1'b0, 32'h100, 1'b0, 32'h0,
                32'h0050_0093, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF,
                2, 32'h1234_5678, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF,
                32'h0, 1'b0, 2};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0,
                3, 32'hCAFE_F00D, 1'b1, 32'h3000, 1'b0, 32'h0,
                32'hCAFE_F00D, 1'b0, 3};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0,
                0, 32'h7777_7777, 1'b1, 32'h4000, 1'b0, 32'h0,
                32'h0, 1'b1, 16};
    vecs[4] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0,
                16, 32'hA5A5_A5A5, 1'b0, 32'h104, 1'b0, 32'h0,
                32'hA5A5_A5A5, 1'b0, 16};
    vecs[5] = '{1'b1, 32'h108, 1'b0, 1'b1, 32'h9000, 32'h1357_9BDF,
                2, 32'h0000_0013, 1'b0, 32'h108, 1'b0, 32'h0,
                32'h0000_0013, 1'b0, 2};

    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {i_ack, d_ack, m_req, m_we, bus_err}, 5'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata | m_wdata, 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // m_ack while idle must not start or finish anything
    m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack", {m_req, i_ack, d_ack, bus_err}, 4'b0);
    chk("idle_hold", i_rdata, 32'h0000_0013);

    // reset in the middle of a fetch
    i_req = 1'b1; i_addr = 32'h500;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    chk("mid_busy", m_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {m_req, i_ack, d_ack, bus_err}, 4'b0);
    @(negedge clk);
    chk("mid_after", {m_req, i_ack, d_ack, bus_err}, 4'b0);
    f = vecs[0];
    f.i_addr = 32'h600; f.exp_addr = 32'h600;
    f.mrd = 32'h0000_6666; f.exp_rdata = 32'h0000_6666;
    run_txn(f);

    // tie after reset: alternating grants starting with fetch
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    m_rdata = 32'h0000_0001;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      m_ack = m_req;
      if (i_ack || d_ack) begin
        got[n] = d_ack ? 1 : 0;
        n++;
        if (n == 4) begin i_req = 0; d_req = 0; end
      end
    end
    m_ack = 1'b0;
    chk("tie_count", n, 4);
    for (int g = 0; g < 4; g++)
      chk($sformatf("tie_grant%0d", g), (n > g) ? got[g] : -1, g % 2);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
